// File: rtl/vrf_arbiter_mc_if.sv
// Client-side bundle of the multi-channel VRF arbiter: per-channel read/write
// requests, grants and the tagged read-return bus.
interface vrf_arbiter_mc_if #(
   parameter int NUM_RD_CH      = 4,
   parameter int NUM_WR_CH      = 4,
   parameter int VRF_ADDR_WIDTH = 10,
   parameter int VRF_DATA_WIDTH = 1024
);
   logic [NUM_RD_CH-1:0]                rd_req;
   logic [NUM_RD_CH*VRF_ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD_CH-1:0]                rd_gnt;
   logic [NUM_RD_CH-1:0]                rd_valid;
   logic [VRF_DATA_WIDTH-1:0]           rd_data;
   logic [NUM_WR_CH-1:0]                wr_req;
   logic [NUM_WR_CH*VRF_ADDR_WIDTH-1:0] wr_addr;
   logic [NUM_WR_CH*VRF_DATA_WIDTH-1:0] wr_data;
   logic [NUM_WR_CH-1:0]                wr_gnt;

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output rd_gnt, rd_valid, rd_data, wr_gnt
   );

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  rd_gnt, rd_valid, rd_data, wr_gnt
   );
endinterface

// File: rtl/vrf_arbiter_mc.sv
// Multi-channel round-robin arbiter for the dual-port VRF BRAM: port A takes
// writes, port B takes reads, with a latency-matched return tag pipeline.
module vrf_arbiter_mc #(
   parameter int NUM_RD_CH      = 4,
   parameter int NUM_WR_CH      = 4,
   parameter int VRF_ADDR_WIDTH = 10,
   parameter int VRF_DATA_WIDTH = 1024,
   parameter int RD_LATENCY     = 1,
   parameter int BYPASS_EN      = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   vrf_arbiter_mc_if.slave           cl,
   output logic [VRF_ADDR_WIDTH-1:0] bram_a_addr_o,
   output logic [VRF_DATA_WIDTH-1:0] bram_a_din_o,
   output logic                      bram_a_en_o,
   output logic                      bram_a_we_o,
   input  logic [VRF_DATA_WIDTH-1:0] bram_a_dout_i,
   output logic [VRF_ADDR_WIDTH-1:0] bram_b_addr_o,
   output logic                      bram_b_en_o,
   output logic                      bram_b_we_o,
   output logic [VRF_DATA_WIDTH-1:0] bram_b_din_o,
   input  logic [VRF_DATA_WIDTH-1:0] bram_b_dout_i
);
   localparam int AW  = VRF_ADDR_WIDTH;
   localparam int DW  = VRF_DATA_WIDTH;
   localparam int RPW = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1;
   localparam int WPW = (NUM_WR_CH > 1) ? $clog2(NUM_WR_CH) : 1;
   localparam int L   = RD_LATENCY;

   logic [RPW-1:0]       rd_ptr_q, rd_ptr_d, rd_id, rd_idx;
   logic [WPW-1:0]       wr_ptr_q, wr_ptr_d, wr_id, wr_idx;
   logic [NUM_RD_CH-1:0] rd_gnt_c;
   logic [NUM_WR_CH-1:0] wr_gnt_c;
   logic                 rd_hit, wr_hit, coll;
   logic [AW-1:0]        rd_addr_c, wr_addr_c;
   logic [DW-1:0]        wr_din_c;

   logic                 vld_q [L];
   logic [RPW-1:0]       id_q  [L];
   logic                 flg_q [L];
   logic [DW-1:0]        byp_q [L];

   logic                 unused_a;
   assign unused_a = ^bram_a_dout_i;

   // Read port: first request at or above the pointer, wrapping; grants masked in reset.
   always_comb begin
      rd_gnt_c  = '0;
      rd_id     = '0;
      rd_idx    = '0;
      rd_hit    = 1'b0;
      rd_addr_c = '0;
      for (int i = 0; i < NUM_RD_CH; i++) begin
         rd_idx = RPW'((int'(rd_ptr_q) + i) % NUM_RD_CH);
         if (!rst && !rd_hit && cl.rd_req[rd_idx]) begin
            rd_hit           = 1'b1;
            rd_id            = rd_idx;
            rd_gnt_c[rd_idx] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_RD_CH; i++)
         if (rd_gnt_c[i]) rd_addr_c = cl.rd_addr[i*AW +: AW];
      rd_ptr_d = rd_hit ? RPW'((int'(rd_id) + 1) % NUM_RD_CH) : rd_ptr_q;
   end

   always_comb begin
      wr_gnt_c  = '0;
      wr_id     = '0;
      wr_idx    = '0;
      wr_hit    = 1'b0;
      wr_addr_c = '0;
      wr_din_c  = '0;
      for (int i = 0; i < NUM_WR_CH; i++) begin
         wr_idx = WPW'((int'(wr_ptr_q) + i) % NUM_WR_CH);
         if (!rst && !wr_hit && cl.wr_req[wr_idx]) begin
            wr_hit           = 1'b1;
            wr_id            = wr_idx;
            wr_gnt_c[wr_idx] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_WR_CH; i++)
         if (wr_gnt_c[i]) begin
            wr_addr_c = cl.wr_addr[i*AW +: AW];
            wr_din_c  = cl.wr_data[i*DW +: DW];
         end
      wr_ptr_d = wr_hit ? WPW'((int'(wr_id) + 1) % NUM_WR_CH) : wr_ptr_q;
   end

   // BRAM reads old contents on a same-address write, so the new data rides along.
   assign coll = (BYPASS_EN != 0) && rd_hit && wr_hit && (rd_addr_c == wr_addr_c);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int s = 0; s < L; s++) begin
            vld_q[s] <= 1'b0;
            id_q[s]  <= '0;
            flg_q[s] <= 1'b0;
            byp_q[s] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         vld_q[0] <= rd_hit;
         id_q[0]  <= rd_id;
         flg_q[0] <= coll;
         byp_q[0] <= wr_din_c;
         for (int s = 1; s < L; s++) begin
            vld_q[s] <= vld_q[s-1];
            id_q[s]  <= id_q[s-1];
            flg_q[s] <= flg_q[s-1];
            byp_q[s] <= byp_q[s-1];
         end
      end
   end

   assign cl.rd_gnt   = rd_gnt_c;
   assign cl.wr_gnt   = wr_gnt_c;
   assign cl.rd_valid = vld_q[L-1] ? (NUM_RD_CH'(1) << id_q[L-1]) : '0;
   assign cl.rd_data  = flg_q[L-1] ? byp_q[L-1] : bram_b_dout_i;

   assign bram_a_en_o   = wr_hit;
   assign bram_a_we_o   = wr_hit;
   assign bram_a_addr_o = wr_addr_c;
   assign bram_a_din_o  = wr_din_c;
   assign bram_b_en_o   = rd_hit;
   assign bram_b_addr_o = rd_addr_c;
   assign bram_b_we_o   = 1'b0;
   assign bram_b_din_o  = '0;
endmodule

// File: tb/tb_vrf_arbiter_mc.sv
// Directed bench for vrf_arbiter_mc with a behavioural BRAM and a read-return
// scoreboard keyed on grant cycle, channel and expected data.
module tb_vrf_arbiter_mc;
   localparam int NR  = 4;
   localparam int NW  = 4;
   localparam int AW  = 10;
   localparam int DW  = 32;
   localparam int RDL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_din, a_dout, b_din, b_dout;
   logic          a_en, a_we, b_en, b_we;

   vrf_arbiter_mc_if #(.NUM_RD_CH(NR), .NUM_WR_CH(NW), .VRF_ADDR_WIDTH(AW),
                       .VRF_DATA_WIDTH(DW)) cl ();

   vrf_arbiter_mc #(.NUM_RD_CH(NR), .NUM_WR_CH(NW), .VRF_ADDR_WIDTH(AW),
                    .VRF_DATA_WIDTH(DW), .RD_LATENCY(RDL), .BYPASS_EN(1)) dut (
      .clk(clk), .rst(rst), .cl(cl),
      .bram_a_addr_o(a_addr), .bram_a_din_o(a_din), .bram_a_en_o(a_en),
      .bram_a_we_o(a_we), .bram_a_dout_i(a_dout),
      .bram_b_addr_o(b_addr), .bram_b_en_o(b_en), .bram_b_we_o(b_we),
      .bram_b_din_o(b_din), .bram_b_dout_i(b_dout)
   );

   // Behavioural BRAM: read-before-write on collision, RDL cycles enable-to-dout.
   logic [DW-1:0] mem [1024];
   logic [DW-1:0] dpipe [RDL];
   assign a_dout = '0;
   assign b_dout = dpipe[RDL-1];
   always @(posedge clk) begin
      if (a_en && a_we) mem[a_addr] <= a_din;
      if (b_en) dpipe[0] <= mem[b_addr];
      for (int s = 1; s < RDL; s++) dpipe[s] <= dpipe[s-1];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [NR-1:0] oh;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t          sbq[$];
   logic [DW-1:0] ref_mem [1024];

   // Scoreboard: pop/check returns, then push new reads (write-first) and update the model.
   always @(negedge clk) begin
      exp_t          e;
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] wd;
      if (rst) begin
         sbq.delete();
      end else begin
         if (cl.rd_valid !== '0) begin
            if (sbq.size() == 0) chk("unexpected_valid", cl.rd_valid, 0);
            else begin
               e = sbq.pop_front();
               chk("ret_channel", cl.rd_valid, e.oh);
               chk("ret_data", cl.rd_data, e.data);
               chk("ret_latency", cyc, e.due);
            end
         end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("missing_valid", cl.rd_valid, e.oh);
         end
         chk("rd_gnt_onehot0", $onehot0(cl.rd_gnt), 1);
         chk("wr_gnt_onehot0", $onehot0(cl.wr_gnt), 1);
         ra = '0; wa = '0; wd = '0;
         for (int k = 0; k < NR; k++) if (cl.rd_gnt[k]) ra = cl.rd_addr[k*AW +: AW];
         for (int k = 0; k < NW; k++)
            if (cl.wr_gnt[k]) begin
               wa = cl.wr_addr[k*AW +: AW];
               wd = cl.wr_data[k*DW +: DW];
            end
         if (cl.rd_gnt != '0) begin
            e.oh   = cl.rd_gnt;
            e.data = (cl.wr_gnt != '0 && wa == ra) ? wd : ref_mem[ra];
            e.due  = cyc + RDL;
            sbq.push_back(e);
         end
         if (cl.wr_gnt != '0) ref_mem[wa] = wd;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      for (int s = 0; s < RDL; s++) dpipe[s] = '0;
      cl.rd_req = '1;
      cl.wr_req = '1;
      for (int i = 0; i < NR; i++) cl.rd_addr[i*AW +: AW] = AW'(12'h100 + (i + 1) % NR);
      for (int i = 0; i < NW; i++) begin
         cl.wr_addr[i*AW +: AW] = AW'(12'h100 + i);
         cl.wr_data[i*DW +: DW] = 32'hC0DE_0000 + DW'(i);
      end

      // Reset with every request high.
      repeat (2) @(posedge clk);
      #4;
      chk("rst_rd_gnt", cl.rd_gnt, 0);
      chk("rst_wr_gnt", cl.wr_gnt, 0);
      chk("rst_rd_valid", cl.rd_valid, 0);
      chk("rst_a_en", a_en, 0);
      chk("rst_a_we", a_we, 0);
      chk("rst_b_en", b_en, 0);
      chk("rst_b_we", b_we, 0);

      // Release: grants start at ch0 and rotate 0,1,2,3,0,1,2,3.
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         settle();
         chk("rr_rd_gnt", cl.rd_gnt, 1 << (i % NR));
         chk("rr_wr_gnt", cl.wr_gnt, 1 << (i % NW));
         tick();
      end
      cl.rd_req = '0;
      cl.wr_req = '0;

      // Move the read pointer to 1, then 4'b1001 wraps 3,0,3.
      cl.rd_req = 4'b0001;
      settle(); chk("ptr_setup", cl.rd_gnt, 4'b0001);
      tick();
      cl.rd_req = 4'b1001;
      settle(); chk("wrap_1", cl.rd_gnt, 4'b1000);
      tick();
      settle(); chk("wrap_2", cl.rd_gnt, 4'b0001);
      tick();
      settle(); chk("wrap_3", cl.rd_gnt, 4'b1000);
      tick();
      cl.rd_req = '0;

      // Write A5.. to 0x010 on ch1, then read it on ch2.
      cl.wr_addr[1*AW +: AW] = 10'h010;
      cl.wr_data[1*DW +: DW] = 32'hA5A5_A5A5;
      cl.wr_req = 4'b0010;
      settle();
      chk("wr_gnt_ch1", cl.wr_gnt, 4'b0010);
      chk("a_en", a_en, 1);
      chk("a_addr", a_addr, 10'h010);
      chk("a_din", a_din, 32'hA5A5_A5A5);
      tick();
      cl.wr_req = '0;
      cl.rd_addr[2*AW +: AW] = 10'h010;
      cl.rd_req = 4'b0100;
      settle();
      chk("rd_gnt_ch2", cl.rd_gnt, 4'b0100);
      chk("b_en", b_en, 1);
      chk("b_addr", b_addr, 10'h010);
      tick();
      cl.rd_req = '0;
      settle(); chk("lat_early_valid", cl.rd_valid, 0);
      tick();
      settle();
      chk("lat_valid", cl.rd_valid, 4'b0100);
      chk("lat_data", cl.rd_data, 32'hA5A5_A5A5);
      tick();

      // Same-cycle write/read collision on 0x3FF (old contents 0).
      cl.wr_addr[1*AW +: AW] = 10'h3FF;
      cl.wr_data[1*DW +: DW] = 32'h5555_5555;
      cl.rd_addr[0*AW +: AW] = 10'h3FF;
      cl.wr_req = 4'b0010;
      cl.rd_req = 4'b0001;
      settle();
      chk("coll_rd_gnt", cl.rd_gnt, 4'b0001);
      chk("coll_wr_gnt", cl.wr_gnt, 4'b0010);
      tick();
      cl.wr_req = '0;
      cl.rd_req = '0;
      tick();
      settle();
      chk("coll_valid", cl.rd_valid, 4'b0001);
      chk("coll_data", cl.rd_data, 32'h5555_5555);
      chk("coll_raw_dout", b_dout, 0);
      tick();

      // Reset one cycle after a grant drops that read and clears both pointers.
      cl.rd_req = 4'b0010;
      settle(); chk("mf_rd_gnt", cl.rd_gnt, 4'b0010);
      tick();
      cl.rd_req = '0;
      rst = 1'b1;
      settle(); chk("mf_valid_a", cl.rd_valid, 0);
      tick();
      settle(); chk("mf_valid_b", cl.rd_valid, 0);
      tick();
      rst = 1'b0;
      cl.rd_req = '1;
      cl.wr_req = '1;
      settle();
      chk("mf_rd_ptr0", cl.rd_gnt, 4'b0001);
      chk("mf_wr_ptr0", cl.wr_gnt, 4'b0001);
      tick();
      cl.rd_req = '0;
      cl.wr_req = '0;
      repeat (RDL + 3) tick();
      chk("sb_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/vrf_arbiter_mc.md
Name: vrf_arbiter_mc

Overview:
- Multi-channel arbiter in front of the dual-port vector register file BRAM, for routers with several read and write clients.
- Generalises the single read/single write arbiter to NUM_RD_CH read channels and NUM_WR_CH write channels.
- Uses independent round-robin arbitration per BRAM port: port A carries writes only, port B carries reads only.
- Adds configurable BRAM read latency, per-channel return tagging and same-cycle read/write collision bypass.

Parameters:
- NUM_RD_CH, 4, number of read client channels (1..8).
- NUM_WR_CH, 4, number of write client channels (1..8).
- VRF_ADDR_WIDTH, 10, BRAM address width.
- VRF_DATA_WIDTH, 1024, BRAM data width.
- RD_LATENCY, 1, BRAM port B clocks from enable to valid dout (1..3).
- BYPASS_EN, 1, 1 = return write data on a same-cycle same-address collision; 0 = return raw BRAM dout.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  NUM_RD_CH  read request per channel; held until granted.
- rd_addr  in  NUM_RD_CH*VRF_ADDR_WIDTH  read address, channel i at slice i.
- rd_gnt  out  NUM_RD_CH  one-hot read grant, same cycle as the request is accepted.
- rd_valid  out  NUM_RD_CH  one-hot read data valid, tagged to the requesting channel.
- rd_data  out  VRF_DATA_WIDTH  shared read return data, qualified by rd_valid.
- wr_req  in  NUM_WR_CH  write request per channel; held until granted.
- wr_addr  in  NUM_WR_CH*VRF_ADDR_WIDTH  write address per channel.
- wr_data  in  NUM_WR_CH*VRF_DATA_WIDTH  write data per channel.
- wr_gnt  out  NUM_WR_CH  one-hot write grant; the write commits on this edge.
- bram_a_addr_o / bram_a_din_o / bram_a_en_o / bram_a_we_o  out  AW/DW/1/1  BRAM write port.
- bram_a_dout_i  in  DW  unused; no functional effect.
- bram_b_addr_o / bram_b_en_o  out  AW/1  BRAM read port.
- bram_b_we_o  out  1  tied 0.
- bram_b_din_o  out  DW  tied 0.
- bram_b_dout_i  in  DW  BRAM read data.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - rd_gnt, wr_gnt, rd_valid = 0.
  - bram_*_en/we = 0.
  - Both RR pointers = 0; latency pipeline and bypass registers cleared.
  - While rst=1, grants are forced 0.
  - Reset mid-operation drops in-flight reads; no rd_valid is issued for them.
- Arbitration (per port, independent, combinational from req and pointer):
  - The grant goes to the first asserted req at or above the pointer, wrapping around modulo N.
  - At most one read grant and one write grant per cycle.
  - On a grant to channel k, the pointer is set to (k+1) mod N on the clock edge; with no grant the pointer holds.
  - A client drops req the cycle after gnt or holds it for back-to-back accesses; a held req is re-arbitrated fairly.
  - Non-granted requests wait; there is no timeout.
- Write path: bram_a_en_o = bram_a_we_o = |wr_gnt; addr and din are muxed from the granted channel. Throughput is 1 write per cycle.
- Read path:
  - bram_b_en_o = |rd_gnt; addr is muxed from the granted channel.
  - A RD_LATENCY-deep shift register carries {valid, channel id, collision flag, bypass data}.
  - rd_valid[id] asserts exactly RD_LATENCY cycles after rd_gnt, for 1 cycle.
  - rd_data = bram_b_dout_i, or bypass data if the flag is set; rd_data is don't-care when rd_valid = 0.
  - Throughput is 1 read per cycle, fully pipelined.
- Collision: when a read grant and a write grant occur in the same cycle with equal addresses and BYPASS_EN=1, the flag is set and the write data is captured. The read then returns the new data (write-first).
- Ordering: a read returns the value of all writes granted up to and including its issue cycle. Writes granted after the issue cycle are not visible to that read.
- Single-channel configs (N=1): the arbiter degenerates to gnt = req.

Test Plan:
- Reset: assert rst with all reqs high -> all gnt/valid/en = 0; after release, the first grants go to rd ch0 and wr ch0.
- RR fairness: NUM_RD_CH=4, all rd_req held high for 8 cycles -> rd_gnt sequence 0,1,2,3,0,1,2,3.
- RR wrap: rd_req = 4'b1001 with pointer at 1 -> grant ch3, then ch0, then ch3.
- Read latency: RD_LATENCY=2; write 0xA5..A5 to addr 0x010, then ch2 reads 0x010 -> rd_valid = 4'b0100 exactly 2 cycles after rd_gnt, with rd_data = 0xA5..A5.
- Collision: mem[0x3FF] = 0, then the same cycle sees wr ch1 addr 0x3FF data 0x55..55 and rd ch0 addr 0x3FF:
  - BYPASS_EN=1 -> rd_data = 0x55..55.
  - BYPASS_EN=0 -> raw dout passthrough.
- Reset mid-flight: rd_gnt issued with RD_LATENCY=3, rst asserted one cycle later -> no rd_valid ever appears for that read; pointers return to 0.
